// File: rtl/imem_loader.sv
// imem_loader
//   Writer side of the core's instruction memory. It takes a framed byte
//   stream (HDR, LEN, LEN data bytes, CHK) and writes the data bytes into the
//   program RAM, starting at address 0. CHK is the XOR of the data bytes only.
//   The core is held in reset until a complete frame with a good checksum has
//   been written.
//
//   Optional build macro: IMEM_LOADER_TIMEOUT_EN
//     When defined, a 16-bit idle counter runs in LEN/DATA/CHK. It clears on
//     every accepted byte. If it reaches 16'hFFFF and another cycle passes
//     without a byte, the frame is rejected (ERR).
//     When undefined, the loader waits in those states indefinitely.
//
//   Ports
//     clk          in   system clock, rising edge
//     reset        in   asynchronous, active-high reset
//     in_data      in   stream byte
//     in_valid     in   in_data valid
//     in_ready     out  loader can accept (always 1 outside reset)
//     mem_we       out  program RAM write strobe (one cycle per data byte)
//     mem_waddr    out  program RAM write address
//     mem_wdata    out  program RAM write data
//     core_hold    out  core reset, 1 = core held
//     load_done    out  a valid program is loaded
//     load_err     out  the last frame was rejected
//     words_loaded out  data bytes written by the current or last frame
//     dbg_state    out  FSM state (IDLE=0 LEN=1 DATA=2 CHK=3 DONE=4 ERR=5)
//
//   Handshake: a byte transfers on a rising clk edge where in_valid and
//   in_ready are both 1. The loader never back-pressures, so in_ready is
//   only low while reset is asserted.

module imem_loader #(
  parameter int                ADDR_W = 4,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] HDR    = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  // Largest legal LEN: the full RAM depth.
  localparam logic [DATA_W-1:0] MAX_LEN = DATA_W'(1 << ADDR_W);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef IMEM_LOADER_TIMEOUT_EN
  logic [15:0]       idle_q, idle_d;
`endif

  logic            accept;
  logic [ADDR_W:0] words_inc;

  assign in_ready  = ~reset;
  assign accept    = in_valid & in_ready;
  assign words_inc = words_q + 1'b1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    words_d = words_q;
    acc_d   = acc_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    err_d   = err_q;
`ifdef IMEM_LOADER_TIMEOUT_EN
    idle_d  = '0;
`endif

    case (state_q)
      // HDR starts a new frame from idle, after success (reload) or after a
      // rejection. Clearing done_q re-asserts core_hold on the next cycle.
      IDLE, DONE, ERR: begin
        if (accept && in_data == HDR) begin
          state_d = LEN;
          words_d = '0;
          err_d   = 1'b0;
          done_d  = 1'b0;
        end
      end

      LEN: begin
        if (accept) begin
          if (in_data == '0 || in_data > MAX_LEN) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            len_d   = in_data[ADDR_W:0];
            words_d = '0;
            acc_d   = '0;
            state_d = DATA;
          end
        end
      end

      // The write pointer is the low ADDR_W bits of the byte count; it never
      // wraps because the frame leaves DATA after the LEN-th byte.
      DATA: begin
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = words_q[ADDR_W-1:0];
          wdata_d = in_data;
          words_d = words_inc;
          acc_d   = acc_q ^ in_data;
          if (words_inc == len_q) begin
            state_d = CHK;
          end
        end
      end

      CHK: begin
        if (accept) begin
          if (in_data == acc_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef IMEM_LOADER_TIMEOUT_EN
    // Only a stalled frame counts; any accepted byte restarts the count.
    if ((state_q == LEN || state_q == DATA || state_q == CHK) && !accept) begin
      if (idle_q == 16'hFFFF) begin
        state_d = ERR;
        err_d   = 1'b1;
      end else begin
        idle_d = idle_q + 16'd1;
      end
    end
`endif
  end

  // RAM contents are outside this block, so a reset mid-frame simply drops
  // the frame and leaves whatever was already written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      words_q <= '0;
      acc_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef IMEM_LOADER_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      words_q <= words_d;
      acc_q   <= acc_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef IMEM_LOADER_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign mem_we       = we_q;
  assign mem_waddr    = waddr_q;
  assign mem_wdata    = wdata_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  // Only a checksum-valid frame releases the core.
  assign core_hold    = ~done_q;
  assign words_loaded = words_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed frames with hand-computed RAM writes
// and status flags.

module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       core_hold;
  logic       load_done;
  logic       load_err;
  logic [4:0] words_loaded;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Observed writes {addr, data} and the cycle each was seen in.
  logic [11:0] wr_q[$];
  int          wr_cyc_q[$];
  // Expected writes {addr, data}.
  logic [11:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_loader dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .core_hold    (core_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded),
    .dbg_state    (dbg_state)
  );

  // Write monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_q.push_back({mem_waddr, mem_wdata});
      wr_cyc_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
  endtask

  task automatic bus_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h00;
    end
    #1;
  endtask

  task automatic clear_logs();
    wr_q.delete();
    wr_cyc_q.delete();
    exp_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready_low got=%b exp=0", in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready_high got=%b exp=1", in_ready);
    end
    n_checks++;
    if ({mem_we, mem_waddr, mem_wdata} !== 13'h0) begin
      n_fail++; $display("FAIL reset_mem got=%h exp=0", {mem_we, mem_waddr, mem_wdata});
    end
    n_checks++;
    if ({core_hold, load_done, load_err} !== 3'b100) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=100", {core_hold, load_done, load_err});
    end
    n_checks++;
    if (words_loaded !== 5'd0) begin
      n_fail++; $display("FAIL reset_words got=%0d exp=0", words_loaded);
    end
    n_checks++;
    if (dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state);
    end
  endtask

  task automatic test_basic();
    clear_logs();
    exp_q.push_back({4'd0, 8'h11});
    exp_q.push_back({4'd1, 8'h22});
    exp_q.push_back({4'd2, 8'h44});
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h44); send(8'h77);
    bus_idle(2);
    n_checks++;
    if (wr_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL basic_wr_count got=%0d exp=%0d", wr_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (wr_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL basic_wr%0d got=%h exp=%h", i, wr_q[i], exp_q[i]);
        end
        if (i > 0) begin
          n_checks++;
          if (wr_cyc_q[i] - wr_cyc_q[i-1] !== 1) begin
            n_fail++; $display("FAIL basic_back_to_back%0d gap=%0d exp=1", i, wr_cyc_q[i] - wr_cyc_q[i-1]);
          end
        end
      end
    end
    n_checks++;
    if ({load_done, core_hold, load_err} !== 3'b100) begin
      n_fail++; $display("FAIL basic_flags got=%b exp=100", {load_done, core_hold, load_err});
    end
    n_checks++;
    if (words_loaded !== 5'd3) begin
      n_fail++; $display("FAIL basic_words got=%0d exp=3", words_loaded);
    end
  endtask

  task automatic test_discard();
    clear_logs();
    exp_q.push_back({4'd0, 8'h80});
    send(8'h00); send(8'h3C); send(8'hA5); send(8'h01); send(8'h80); send(8'h80);
    bus_idle(2);
    n_checks++;
    if (wr_q.size() !== 1) begin
      n_fail++; $display("FAIL discard_wr_count got=%0d exp=1", wr_q.size());
    end else begin
      n_checks++;
      if (wr_q[0] !== exp_q[0]) begin
        n_fail++; $display("FAIL discard_wr0 got=%h exp=%h", wr_q[0], exp_q[0]);
      end
    end
    n_checks++;
    if ({load_done, core_hold, load_err, words_loaded} !== {3'b100, 5'd1}) begin
      n_fail++; $display("FAIL discard_status got=%b exp=10000001", {load_done, core_hold, load_err, words_loaded});
    end
  endtask

  task automatic test_bad_chk();
    clear_logs();
    exp_q.push_back({4'd0, 8'h01});
    exp_q.push_back({4'd1, 8'h02});
    send(8'hA5); send(8'h02); send(8'h01); send(8'h02); send(8'hFF);
    bus_idle(2);
    n_checks++;
    if (wr_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL badchk_wr_count got=%0d exp=%0d", wr_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (wr_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL badchk_wr%0d got=%h exp=%h", i, wr_q[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if ({load_err, core_hold, load_done} !== 3'b110) begin
      n_fail++; $display("FAIL badchk_flags got=%b exp=110", {load_err, core_hold, load_done});
    end
    n_checks++;
    if (dbg_state !== 3'd5) begin
      n_fail++; $display("FAIL badchk_state got=%0d exp=5", dbg_state);
    end
  endtask

  task automatic test_bad_len();
    clear_logs();
    send(8'hA5); send(8'h00);
    bus_idle(2);
    n_checks++;
    if ({load_err, core_hold, load_done, dbg_state} !== {3'b110, 3'd5}) begin
      n_fail++; $display("FAIL len0_status got=%b exp=110101", {load_err, core_hold, load_done, dbg_state});
    end
    send(8'hA5); send(8'h11);
    bus_idle(2);
    n_checks++;
    if ({load_err, core_hold, load_done, dbg_state} !== {3'b110, 3'd5}) begin
      n_fail++; $display("FAIL len17_status got=%b exp=110101", {load_err, core_hold, load_done, dbg_state});
    end
    n_checks++;
    if (wr_q.size() !== 0) begin
      n_fail++; $display("FAIL badlen_no_writes got=%0d exp=0", wr_q.size());
    end
    exp_q.push_back({4'd0, 8'h5A});
    send(8'hA5); send(8'h01); send(8'h5A); send(8'h5A);
    bus_idle(2);
    n_checks++;
    if (wr_q.size() !== 1) begin
      n_fail++; $display("FAIL recover_wr_count got=%0d exp=1", wr_q.size());
    end else begin
      n_checks++;
      if (wr_q[0] !== exp_q[0]) begin
        n_fail++; $display("FAIL recover_wr0 got=%h exp=%h", wr_q[0], exp_q[0]);
      end
    end
    n_checks++;
    if ({load_done, core_hold, load_err} !== 3'b100) begin
      n_fail++; $display("FAIL recover_flags got=%b exp=100", {load_done, core_hold, load_err});
    end
  endtask

  task automatic test_full();
    clear_logs();
    send(8'hA5); send(8'h10);
    for (int i = 0; i < 16; i++) begin
      send(8'(i));
      exp_q.push_back({4'(i), 8'(i)});
    end
    send(8'h00);  // XOR of 00..0F
    bus_idle(2);
    n_checks++;
    if (wr_q.size() !== 16) begin
      n_fail++; $display("FAIL full_wr_count got=%0d exp=16", wr_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (wr_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL full_wr%0d got=%h exp=%h", i, wr_q[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (words_loaded !== 5'd16) begin
      n_fail++; $display("FAIL full_words got=%0d exp=16", words_loaded);
    end
    n_checks++;
    if ({load_done, core_hold, load_err} !== 3'b100) begin
      n_fail++; $display("FAIL full_flags got=%b exp=100", {load_done, core_hold, load_err});
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    send(8'hA5); send(8'h05); send(8'h01); send(8'h02);
    bus_idle(1);
    n_checks++;
    if (wr_q.size() !== 2) begin
      n_fail++; $display("FAIL mid_pre_writes got=%0d exp=2", wr_q.size());
    end
    n_checks++;
    if ({core_hold, load_done, dbg_state} !== {2'b10, 3'd2}) begin
      n_fail++; $display("FAIL mid_reload_hold got=%b exp=10010", {core_hold, load_done, dbg_state});
    end
    clear_logs();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({core_hold, load_done, load_err, in_ready, mem_we} !== 5'b10000) begin
      n_fail++; $display("FAIL mid_reset_flags got=%b exp=10000", {core_hold, load_done, load_err, in_ready, mem_we});
    end
    n_checks++;
    if (dbg_state !== 3'd0 || words_loaded !== 5'd0) begin
      n_fail++; $display("FAIL mid_reset_state state=%0d words=%0d exp=0,0", dbg_state, words_loaded);
    end
    @(negedge clk);
    reset = 1'b0;
    send(8'h03); send(8'h04);
    bus_idle(2);
    n_checks++;
    if (wr_q.size() !== 0) begin
      n_fail++; $display("FAIL mid_no_writes got=%0d exp=0", wr_q.size());
    end
    n_checks++;
    if ({core_hold, dbg_state} !== {1'b1, 3'd0}) begin
      n_fail++; $display("FAIL mid_after_state got=%b exp=1000", {core_hold, dbg_state});
    end
  endtask

  task automatic test_timeout();
    logic       exp_err;
    logic [2:0] exp_state;
`ifdef IMEM_LOADER_TIMEOUT_EN
    exp_err   = 1'b1;
    exp_state = 3'd5;
`else
    exp_err   = 1'b0;
    exp_state = 3'd2;
`endif
    clear_logs();
    send(8'hA5); send(8'h02); send(8'h01);
    bus_idle(65600);
    n_checks++;
    if (load_err !== exp_err) begin
      n_fail++; $display("FAIL timeout_err got=%b exp=%b", load_err, exp_err);
    end
    n_checks++;
    if (dbg_state !== exp_state) begin
      n_fail++; $display("FAIL timeout_state got=%0d exp=%0d", dbg_state, exp_state);
    end
    n_checks++;
    if (wr_q.size() !== 1 || core_hold !== 1'b1) begin
      n_fail++; $display("FAIL timeout_writes got=%0d hold=%b exp=1,1", wr_q.size(), core_hold);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_discard();
    test_bad_chk();
    test_bad_len();
    test_full();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
